// File: rtl/nla_engine_scheduler.sv
// Round-robin front end that shares one polynomial approximation engine between
// NUM_REQ requesters: one job in flight, timeout-protected, per-requester responses.
module nla_engine_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 16,
  parameter int FUNC_W     = 2,
  parameter int ADDR_LINES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ*FUNC_W-1:0]   req_func_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        rsp_err_o,
  input  logic                        cfg_we_i,
  input  logic [FUNC_W-1:0]           cfg_func_i,
  input  logic [ADDR_LINES-1:0]       cfg_count_i,
  output logic                        eng_start_o,
  output logic [DATA_W-1:0]           eng_data_o,
  output logic [FUNC_W-1:0]           eng_func_o,
  output logic [ADDR_LINES-1:0]       eng_coeff_count_o,
  input  logic                        eng_done_i,
  input  logic [DATA_W-1:0]           eng_result_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int FUNCS = 1 << FUNC_W;
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        ptr_reg, ptr_next;
  logic [IDX_W-1:0]        grant_reg;
  logic [DATA_W-1:0]       data_reg;
  logic [FUNC_W-1:0]       func_reg;
  logic [ADDR_LINES-1:0]   count_reg;
  logic [DATA_W-1:0]       result_reg, result_next;
  logic                    err_reg, err_next;
  logic [TMR_W-1:0]        timer_reg, timer_next;
  logic [ADDR_LINES-1:0]   count_tbl_reg [FUNCS];

  logic [DATA_W-1:0]       req_data_arr [NUM_REQ];
  logic [FUNC_W-1:0]       req_func_arr [NUM_REQ];
  logic [IDX_W-1:0]        winner;
  logic [IDX_W:0]          cand;
  logic                    capture_en;
  logic [NUM_REQ-1:0]      req_ready_next;
  logic [NUM_REQ-1:0]      rsp_valid_next;
  logic                    eng_start_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
    assign req_func_arr[gi] = req_func_i[gi*FUNC_W +: FUNC_W];
  end

  // Scan offsets from farthest to nearest so the nearest valid index from the pointer wins.
  always_comb begin
    winner = ptr_reg;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (req_valid_i[cand[IDX_W-1:0]]) winner = cand[IDX_W-1:0];
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    timer_next     = timer_reg;
    result_next    = result_reg;
    err_next       = err_reg;
    capture_en     = 1'b0;
    req_ready_next = '0;
    rsp_valid_next = '0;
    eng_start_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_valid_i) begin
          req_ready_next[winner] = 1'b1;
          capture_en             = 1'b1;
          if (count_tbl_reg[req_func_arr[winner]] != '0) begin
            state_next = ST_LAUNCH;
          end else begin
            // Disabled function: answer with an error without touching the engine.
            result_next = '0;
            err_next    = 1'b1;
            state_next  = ST_RESP;
          end
        end
      end
      ST_LAUNCH: begin
        eng_start_next = 1'b1;
        timer_next     = '0;
        state_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done_i) begin
          result_next = eng_result_i;
          err_next    = 1'b0;
          state_next  = ST_RESP;
        end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = ST_RESP;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      ST_RESP: begin
        rsp_valid_next[grant_reg] = 1'b1;
        if (rsp_ready_i[grant_reg]) begin
          ptr_next   = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      grant_reg  <= '0;
      data_reg   <= '0;
      func_reg   <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      timer_reg  <= '0;
      for (int i = 0; i < FUNCS; i++) count_tbl_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      timer_reg  <= timer_next;
      result_reg <= result_next;
      err_reg    <= err_next;
      // Capture reads the table before this cycle's cfg write lands.
      if (capture_en) begin
        grant_reg <= winner;
        data_reg  <= req_data_arr[winner];
        func_reg  <= req_func_arr[winner];
        count_reg <= count_tbl_reg[req_func_arr[winner]];
      end
      if (cfg_we_i) count_tbl_reg[cfg_func_i] <= cfg_count_i;
    end
  end

  // Ready is combinational from req_valid_i, so mask it while reset is held.
  assign req_ready_o       = rstn_i ? req_ready_next : '0;
  assign rsp_valid_o       = rsp_valid_next;
  assign rsp_data_o        = (state_reg == ST_RESP) ? result_reg : '0;
  assign rsp_err_o         = (state_reg == ST_RESP) ? err_reg : 1'b0;
  assign eng_start_o       = eng_start_next;
  assign eng_data_o        = data_reg;
  assign eng_func_o        = func_reg;
  assign eng_coeff_count_o = count_reg;

endmodule

// File: tb/tb_nla_engine_scheduler.sv
// Directed bench for nla_engine_scheduler; the engine is played by the stimulus itself.
module tb_nla_engine_scheduler;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [63:0] req_data_i;
  logic [7:0]  req_func_i;
  logic [3:0]  rsp_valid_o;
  logic [3:0]  rsp_ready_i;
  logic [15:0] rsp_data_o;
  logic        rsp_err_o;
  logic        cfg_we_i;
  logic [1:0]  cfg_func_i;
  logic [3:0]  cfg_count_i;
  logic        eng_start_o;
  logic [15:0] eng_data_o;
  logic [1:0]  eng_func_o;
  logic [3:0]  eng_coeff_count_o;
  logic        eng_done_i;
  logic [15:0] eng_result_i;

  int checks   = 0;
  int failures = 0;

  nla_engine_scheduler #(
    .NUM_REQ(4), .DATA_W(16), .FUNC_W(2), .ADDR_LINES(4), .TIMEOUT(64)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .req_func_i(req_func_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .cfg_we_i(cfg_we_i), .cfg_func_i(cfg_func_i), .cfg_count_i(cfg_count_i),
    .eng_start_o(eng_start_o), .eng_data_o(eng_data_o), .eng_func_o(eng_func_o),
    .eng_coeff_count_o(eng_coeff_count_o),
    .eng_done_i(eng_done_i), .eng_result_i(eng_result_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] f, input logic [3:0] c);
    cfg_we_i = 1'b1; cfg_func_i = f; cfg_count_i = c;
    tick();
    cfg_we_i = 1'b0;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  int g;

  initial begin
    rstn_i = 1'b0; req_valid_i = '0; req_data_i = '0; req_func_i = '0;
    rsp_ready_i = '0; cfg_we_i = 1'b0; cfg_func_i = '0; cfg_count_i = '0;
    eng_done_i = 1'b0; eng_result_i = '0;
    tick(); tick();
    check("rst_ready", req_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_data", {rsp_err_o, rsp_data_o}, 0);
    check("rst_eng", {eng_start_o, eng_data_o, eng_func_o, eng_coeff_count_o}, 0);
    rstn_i = 1'b1;
    tick();

    // Basic transaction: requester 1, func 1 (count 5), done 7 cycles after start.
    cfg_write(2'd1, 4'd5);
    cfg_write(2'd0, 4'd3);
    cfg_write(2'd2, 4'd4);
    req_valid_i = 4'b0010; req_data_i[16 +: 16] = 16'h1234; req_func_i[2 +: 2] = 2'd1;
    #1;
    check("t1_ready", req_ready_o, 4'b0010);
    tick();
    req_valid_i = '0;
    #1;
    check("t1_ready_drop", req_ready_o, 0);
    check("t1_start", eng_start_o, 1);
    check("t1_count", eng_coeff_count_o, 5);
    check("t1_func", eng_func_o, 1);
    check("t1_edata", eng_data_o, 16'h1234);
    tick();
    check("t1_start_pulse", eng_start_o, 0);
    for (int i = 0; i < 6; i++) tick();
    check("t1_wait_novalid", rsp_valid_o, 0);
    eng_done_i = 1'b1; eng_result_i = 16'h0ABC;
    tick();
    eng_done_i = 1'b0;
    #1;
    check("t1_rsp_valid", rsp_valid_o, 4'b0010);
    check("t1_rsp_data", rsp_data_o, 16'h0ABC);
    check("t1_rsp_err", rsp_err_o, 0);
    rsp_ready_i = 4'b0010;
    tick();
    rsp_ready_i = '0;
    #1;
    check("t1_rsp_done", rsp_valid_o, 0);
    $display("txn req=1 data=%h err=%0d", 16'h0ABC, 0);

    // Disabled function: requester 3 with func 3 (count 0), pointer now at 2.
    req_valid_i = 4'b1000; req_data_i[48 +: 16] = 16'h3333; req_func_i[6 +: 2] = 2'd3;
    #1;
    check("t3_ready", req_ready_o, 4'b1000);
    tick();
    req_valid_i = '0;
    #1;
    check("t3_no_start", eng_start_o, 0);
    check("t3_rsp_valid", rsp_valid_o, 4'b1000);
    check("t3_rsp", {rsp_err_o, rsp_data_o}, {1'b1, 16'h0000});
    rsp_ready_i = 4'b1000;
    tick();
    rsp_ready_i = '0;
    $display("txn req=3 data=0000 err=1");

    // Response backpressure: requester 0 func 0 (count 3), others pile up meanwhile.
    req_valid_i = 4'b0001; req_data_i[0 +: 16] = 16'h0055; req_func_i[0 +: 2] = 2'd0;
    #1;
    check("t5_ready", req_ready_o, 4'b0001);
    tick();
    req_valid_i = 4'b1110;
    #1;
    check("t5_count", eng_coeff_count_o, 3);
    tick();
    eng_done_i = 1'b1; eng_result_i = 16'h7777;
    tick();
    eng_done_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", rsp_valid_o, 4'b0001);
      check("t5_hold_data", {rsp_err_o, rsp_data_o}, {1'b0, 16'h7777});
      check("t5_hold_noready", req_ready_o, 0);
      rsp_ready_i = 4'b1110;
      tick();
    end
    rsp_ready_i = 4'b0001;
    tick();
    rsp_ready_i = '0;
    $display("txn req=0 data=7777 err=0");
    check("t5_next_grant", req_ready_o, 4'b0010);

    // Timeout: requester 1 accepted here, engine stays silent.
    tick();
    req_valid_i = '0;
    #1;
    check("t4_start", eng_start_o, 1);
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("t4_still_wait", rsp_valid_o, 0);
    tick();
    check("t4_rsp_valid", rsp_valid_o, 4'b0010);
    check("t4_rsp", {rsp_err_o, rsp_data_o}, {1'b1, 16'h0000});
    eng_done_i = 1'b1; eng_result_i = 16'hBEEF;
    tick();
    eng_done_i = 1'b0;
    check("t4_late_done_ignored", {rsp_err_o, rsp_data_o}, {1'b1, 16'h0000});
    rsp_ready_i = 4'b0010;
    tick();
    rsp_ready_i = '0;
    $display("txn req=1 data=0000 err=1 (timeout)");
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    tick();
    check("t4_no_second_rsp", {rsp_valid_o, eng_start_o}, 0);

    // Reset during WAIT: requester 2 func 2 (count 4).
    req_valid_i = 4'b0100; req_data_i[32 +: 16] = 16'h2222; req_func_i[4 +: 2] = 2'd2;
    #1;
    check("t6_ready", req_ready_o, 4'b0100);
    tick();
    req_valid_i = 4'b0100;
    tick();
    check("t6_count", eng_coeff_count_o, 4);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t6_rst_eng", {eng_start_o, eng_data_o, eng_func_o, eng_coeff_count_o}, 0);
    check("t6_rst_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, 0);
    check("t6_rst_ready", req_ready_o, 0);
    req_valid_i = '0;
    tick(); tick();
    rstn_i = 1'b1;
    tick();
    $display("txn req=2 aborted by reset");

    // Round robin from pointer 0, all requesters valid, immediate response accept.
    cfg_write(2'd0, 4'd3);
    cfg_write(2'd1, 4'd5);
    cfg_write(2'd2, 4'd4);
    req_data_i  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    req_func_i  = {2'd2, 2'd2, 2'd1, 2'd0};
    req_valid_i = 4'b1111;
    rsp_ready_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      g = order[j];
      #1;
      check("rr_ready", req_ready_o, 32'(1) << g);
      tick();
      check("rr_start", eng_start_o, 1);
      check("rr_edata", eng_data_o, 32'h1000 + g);
      tick();
      eng_done_i = 1'b1; eng_result_i = 16'h0A00 + 16'(g);
      tick();
      eng_done_i = 1'b0;
      #1;
      check("rr_rsp_valid", rsp_valid_o, 32'(1) << g);
      check("rr_rsp_data", rsp_data_o, 32'h0A00 + g);
      $display("txn req=%0d data=%h err=%0d", g, rsp_data_o, rsp_err_o);
      tick();
    end
    req_valid_i = '0;
    rsp_ready_i = '0;
    tick();

    // Same-cycle cfg write and capture: requester 1 func 1 must see the old count 5.
    req_valid_i = 4'b0010;
    cfg_we_i = 1'b1; cfg_func_i = 2'd1; cfg_count_i = 4'd9;
    #1;
    check("t7_ready", req_ready_o, 4'b0010);
    tick();
    cfg_we_i = 1'b0; req_valid_i = '0;
    #1;
    check("t7_old_count", eng_coeff_count_o, 5);
    tick();
    eng_done_i = 1'b1; eng_result_i = 16'h5A5A;
    tick();
    eng_done_i = 1'b0;
    check("t7_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {4'b0010, 1'b0, 16'h5A5A});
    rsp_ready_i = 4'b0010;
    tick();
    rsp_ready_i = '0;
    $display("txn req=1 data=5a5a err=0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
